// File: rtl/jacobi_pkg.sv
// Shared definitions for the Jacobi pivot search: sizes, FSM states and
// element helpers used by both the scan controller and the row reducer.
package jacobi_pkg;

  localparam int N      = 32;
  localparam int W      = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_e;

  function automatic logic [W-1:0] elem_slice(input logic [N*W-1:0] row, input int j);
    return row[W*j +: W];
  endfunction

  // The most negative value has no positive twin, so it clamps to the largest positive.
  function automatic logic [W-1:0] abs_sat(input logic [W-1:0] x);
    if (!x[W-1]) return x;
    if (x == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
    return -x;
  endfunction

endpackage

// File: rtl/row_abs_max.sv
// Combinational reduction of one matrix row: largest |a[r][j]| over j > r,
// first occurrence wins on ties.
module row_abs_max
  import jacobi_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic [N*W-1:0]    row_data,
  input  logic [ADDR_W-1:0] row_idx,
  output logic              found,
  output logic [W-1:0]      best_abs,
  output logic [ADDR_W-1:0] best_col,
  output logic [W-1:0]      best_val
);

  always_comb begin
    found    = 1'b0;
    best_abs = '0;
    best_col = '0;
    best_val = '0;
    for (int j = 0; j < N; j++) begin
      if ((j > int'(row_idx)) &&
          (!found || (abs_sat(elem_slice(row_data, j)) > best_abs))) begin
        found    = 1'b1;
        best_abs = abs_sat(elem_slice(row_data, j));
        best_col = ADDR_W'(j);
        best_val = elem_slice(row_data, j);
      end
    end
  end

endmodule

// File: rtl/pivot_finder.sv
// Scans an N x N matrix row by row from a 1-cycle-latency RAM and reports the
// largest-magnitude strict-upper-triangle element plus a convergence flag.
module pivot_finder
  import jacobi_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W-1:0]      tol,
  output logic              ram_ena,
  output logic              ram_read_write,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [N*W-1:0]    ram_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] p,
  output logic [ADDR_W-1:0] q,
  output logic [W-1:0]      apq,
  output logic [W-1:0]      max_abs,
  output logic              converged
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   rd_row_q, rd_row_d;
  logic [W-1:0]        tol_q, tol_d;
  logic [ADDR_W-1:0]   p_q, p_d, q_q, q_d;
  logic [W-1:0]        apq_q, apq_d, max_abs_q, max_abs_d;
  logic                conv_q, conv_d;

  logic                cand_found;
  logic [W-1:0]        cand_abs;
  logic [ADDR_W-1:0]   cand_col;
  logic [W-1:0]        cand_val;
  logic                take_cand;

  row_abs_max #(.N(N), .W(W)) u_row_abs_max (
    .row_data (ram_data),
    .row_idx  (rd_row_q),
    .found    (cand_found),
    .best_abs (cand_abs),
    .best_col (cand_col),
    .best_val (cand_val)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ram_ena = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        ram_ena = 1'b1;
        if (addr_q == ADDR_W'(N-1)) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_read_write = 1'b0;
  assign ram_address    = ram_ena ? addr_q : '0;

  // Row 0 seeds the running result unconditionally; later rows must beat it strictly.
  assign take_cand = rd_valid_q && cand_found && ((rd_row_q == '0) || (cand_abs > max_abs_q));

  always_comb begin
    addr_d     = addr_q;
    if (state_q == IDLE)       addr_d = '0;
    else if (state_q == FETCH) addr_d = addr_q + 1'b1;
    rd_valid_d = (state_q == FETCH);
    rd_row_d   = addr_q;
    tol_d      = ((state_q == IDLE) && start) ? tol : tol_q;
    p_d        = take_cand ? rd_row_q : p_q;
    q_d        = take_cand ? cand_col : q_q;
    apq_d      = take_cand ? cand_val : apq_q;
    max_abs_d  = take_cand ? cand_abs : max_abs_q;
    conv_d     = (state_q == DRAIN) ? (max_abs_q < tol_q) : conv_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_row_q   <= '0;
      tol_q      <= '0;
      p_q        <= '0;
      q_q        <= ADDR_W'(1);
      apq_q      <= '0;
      max_abs_q  <= '0;
      conv_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      rd_valid_q <= rd_valid_d;
      rd_row_q   <= rd_row_d;
      tol_q      <= tol_d;
      p_q        <= p_d;
      q_q        <= q_d;
      apq_q      <= apq_d;
      max_abs_q  <= max_abs_d;
      conv_q     <= conv_d;
    end
  end

  assign p         = p_q;
  assign q         = q_q;
  assign apq       = apq_q;
  assign max_abs   = max_abs_q;
  assign converged = conv_q;

endmodule

// File: tb/tb_pivot_finder.sv
// Scoreboard bench for pivot_finder: a RAM model feeds matrices, a reference
// search predicts each result, and a negedge monitor checks timing and results.
module tb_pivot_finder;

  localparam int N = 32;
  localparam int W = 32;

  typedef struct {
    logic [4:0]   p;
    logic [4:0]   q;
    logic [W-1:0] apq;
    logic [W-1:0] max_abs;
    logic         conv;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   tol;
  logic           ram_ena;
  logic           ram_read_write;
  logic [4:0]     ram_address;
  logic [N*W-1:0] ram_data = '0;
  logic           busy;
  logic           done;
  logic [4:0]     p;
  logic [4:0]     q;
  logic [W-1:0]   apq;
  logic [W-1:0]   max_abs;
  logic           converged;

  logic [W-1:0] mat [N][N];
  exp_t         sbq [$];
  int           cycle_count = 0;
  int           scan_start  = -1;
  bit           armed       = 1'b0;
  int           vectors     = 0;
  int           miscompares = 0;

  pivot_finder #(.N(N), .W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .tol            (tol),
    .ram_ena        (ram_ena),
    .ram_read_write (ram_read_write),
    .ram_address    (ram_address),
    .ram_data       (ram_data),
    .busy           (busy),
    .done           (done),
    .p              (p),
    .q              (q),
    .apq            (apq),
    .max_abs        (max_abs),
    .converged      (converged)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_count++;

  // Synchronous-read RAM: data for the address presented appears next cycle.
  always @(posedge clk) begin
    if (ram_ena && !ram_read_write)
      for (int j = 0; j < N; j++) ram_data[W*j +: W] <= mat[ram_address][j];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle_count, act, expv);
    end
  endtask

  // Direct search over the strict upper triangle with wide arithmetic.
  function automatic exp_t refModel(input logic [W-1:0] tol_val);
    exp_t   e;
    longint best = -1;
    longint v;
    longint a;
    e.p = '0; e.q = 5'd1; e.apq = '0; e.max_abs = '0;
    for (int r = 0; r < N; r++) begin
      for (int j = r + 1; j < N; j++) begin
        v = longint'($signed(mat[r][j]));
        a = (v < 0) ? -v : v;
        if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
        if (a > best) begin
          best    = a;
          e.p     = 5'(r);
          e.q     = 5'(j);
          e.apq   = mat[r][j];
        end
      end
    end
    e.max_abs = best[W-1:0];
    e.conv    = best < longint'({32'b0, tol_val});
    return e;
  endfunction

  task automatic checkResetValues();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ram_ena", ram_ena, 0);
    checkOutput("rst_ram_address", ram_address, 0);
    checkOutput("rst_p", p, 0);
    checkOutput("rst_q", q, 1);
    checkOutput("rst_apq", apq, 0);
    checkOutput("rst_max_abs", max_abs, 0);
    checkOutput("rst_converged", converged, 0);
  endtask

  // Runs one scan; pulse_a/pulse_b re-assert start at those cycles, abort_at resets mid-scan.
  task automatic applyStimulus(input logic [W-1:0] tol_val, input int pulse_a, input int pulse_b,
                               input int abort_at);
    exp_t e;
    @(negedge clk); #1;
    tol = tol_val;
    e = refModel(tol_val);
    sbq.push_back(e);
    start = 1'b1;
    scan_start = cycle_count;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk); #1;
      start = (k == pulse_a) || (k == pulse_b);
      if (k == abort_at) begin
        start = 1'b0;
        reset = 1'b1;
        sbq.delete(sbq.size() - 1);
        scan_start = -1;
        @(negedge clk);
        checkResetValues();
        #1 reset = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic clearMatrix();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) mat[r][j] = '0;
  endtask

  task automatic randomMatrix(input int mode);
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        case (mode)
          0:       mat[r][j] = $urandom;
          1:       mat[r][j] = W'($signed($urandom_range(0, 8)) - 4);
          default: mat[r][j] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 2000)) - 32'd1000 : '0;
        endcase
  endtask

  // Per-cycle timing checks against the bench's own notion of the active scan.
  always @(negedge clk) begin
    int   k;
    logic exp_busy, exp_ena, exp_done;
    logic [4:0] exp_addr;
    exp_t e;
    if (armed) begin
      k        = (scan_start >= 0) ? (cycle_count - scan_start) : -1;
      exp_busy = (k >= 1) && (k <= N + 2);
      exp_ena  = (k >= 1) && (k <= N);
      exp_done = (k == N + 2);
      exp_addr = exp_ena ? 5'(k - 1) : 5'd0;
      checkOutput("busy", busy, exp_busy);
      checkOutput("ram_ena", ram_ena, exp_ena);
      checkOutput("ram_address", ram_address, exp_addr);
      checkOutput("ram_read_write", ram_read_write, 0);
      checkOutput("done", done, exp_done);
      if (done === 1'b1) begin
        checkOutput("done_has_expectation", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          checkOutput("p", p, e.p);
          checkOutput("q", q, e.q);
          checkOutput("apq", apq, e.apq);
          checkOutput("max_abs", max_abs, e.max_abs);
          checkOutput("converged", converged, e.conv);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t pre;
    logic [W-1:0] tv;
    reset = 1'b1;
    start = 1'b0;
    tol   = '0;
    clearMatrix();
    repeat (2) @(negedge clk);
    armed = 1'b1;
    checkResetValues();
    #1 reset = 1'b0;

    for (int i = 0; i < N; i++) mat[i][i] = 32'd1;
    applyStimulus(32'd1, -1, -1, -1);

    clearMatrix();
    mat[3][17] = -32'sd500;
    mat[17][3] = -32'sd500;
    applyStimulus(32'd10, -1, -1, -1);

    randomMatrix(1);
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        if (r != j) mat[r][j] = W'($signed($urandom_range(0, 78)) - 39);
    mat[2][5] = 32'd40; mat[7][9] = 32'd40; mat[2][30] = 32'd40;
    applyStimulus(32'd100, -1, -1, -1);

    clearMatrix();
    mat[0][31] = 32'h8000_0000;
    mat[1][2]  = 32'h7FFF_FFFF;
    applyStimulus(32'hFFFF_FFFF, -1, -1, -1);

    randomMatrix(0);
    applyStimulus($urandom, -1, -1, 10);
    applyStimulus($urandom, -1, -1, -1);

    randomMatrix(2);
    applyStimulus(32'd300, 5, N + 2, -1);

    @(negedge clk); #1;
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkResetValues();
    #1 reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);

    for (int n = 0; n < 9; n++) begin
      randomMatrix(n % 3);
      pre = refModel('0);
      case (n % 3)
        0:       tv = pre.max_abs;
        1:       tv = pre.max_abs + 32'd1;
        default: tv = $urandom;
      endcase
      applyStimulus(tv, -1, -1, -1);
    end

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pivot_finder.md
PIVOT_FINDER -- requirements
Module: pivot_finder

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning matrix dimension (rows = RAM words = elements per word).
REQ-002 The block SHALL have parameter W, default 32, meaning element width in bits, two's-complement signed.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, meaning a one-cycle request to begin a scan.
REQ-006 The block SHALL have port tol, input, W bits, meaning unsigned convergence threshold.
REQ-007 The block SHALL have port ram_ena, output, 1 bit, meaning RAM enable.
REQ-008 The block SHALL have port ram_read_write, output, 1 bit, meaning RAM direction; it is held at 0 (read) at all times.
REQ-009 The block SHALL have port ram_address, output, 5 bits, meaning RAM row address.
REQ-010 The block SHALL have port ram_data, input, N*W bits, meaning RAM read port 1; element j occupies bits [W*j+W-1 : W*j].
REQ-011 The block SHALL have ports busy (1 bit), done (1 bit), p (5 bits), q (5 bits), apq (W bits), max_abs (W bits) and converged (1 bit), all outputs.

Function
REQ-012 FSM states SHALL be IDLE, FETCH, DRAIN and DONE.
- IDLE to FETCH: on start.
- FETCH to DRAIN: after address N-1 is issued.
- DRAIN to DONE: after one cycle.
- DONE to IDLE: after one cycle.
REQ-013 A scan SHALL run on the following timeline, where cycle 0 is the cycle in which start is sampled:
- cycle k = 1..N: ram_ena=1 and ram_address=k-1.
- RAM read latency is 1 cycle.
- Row r data SHALL be evaluated in cycle r+2.
REQ-014 Only the strict upper triangle SHALL be searched: elements with column j > row r. The diagonal and the lower triangle are ignored.
REQ-015 |x| SHALL be computed in W bits; the most negative value SHALL saturate to 2^(W-1)-1.
REQ-016 The running maximum SHALL be replaced only when a candidate is strictly greater. Ties therefore resolve to the lowest r, then the lowest j.
REQ-017 Running result registers (p, q, apq, max_abs) SHALL initialise at scan start to p=0, q=1, apq=a[0][1], max_abs=|a[0][1]|, loaded in cycle 2.
REQ-018 done SHALL be a one-cycle pulse in cycle N+2 (cycle 34 for N=32).
REQ-019 converged SHALL be computed as max_abs < tol (unsigned compare), be registered, and become valid together with done.
REQ-020 p, q, apq, max_abs and converged SHALL hold their values from done until the next scan's cycle 2.
REQ-021 busy SHALL be 1 from cycle 1 through cycle N+2 inclusive.
REQ-022 start SHALL be ignored while busy=1; a start pulse in the same cycle as done SHALL be ignored.
REQ-023 ram_ena SHALL be 0 outside the FETCH state.
REQ-024 ram_address SHALL be 0 when ram_ena=0.
REQ-025 tol SHALL be sampled at start and SHALL be stable for the remainder of the scan.

Reset
REQ-026 While reset=1, at the next edge the FSM SHALL go to IDLE and busy, done, ram_ena, ram_address, p, apq, max_abs and converged SHALL be 0, and q SHALL be 1.
REQ-027 A reset asserted mid-scan SHALL abort the scan with no done pulse.
REQ-028 A start coincident with reset SHALL be ignored.

Structure
REQ-029 Shared package jacobi_pkg SHALL hold N, W, ADDR_W=5, the FSM state enum, and the element-slice and abs-saturate functions.
REQ-030 The design SHALL contain one sub-module, row_abs_max.
- It is combinational.
- Inputs: one row and the row index.
- Outputs: the max |a[r][j]| over j > r, its column, and its signed value, using the same tie rule as REQ-016.
REQ-031 Row r=N-1 SHALL produce no valid candidate and SHALL leave the running result unchanged.

Verification
REQ-032 Identity matrix with tol=1: expect done at cycle 34, p=0, q=1, apq=0, max_abs=0, converged=1.
REQ-033 All zeros except a[3][17]=-500 and a[17][3]=-500, tol=10: expect p=3, q=17, apq=-500, max_abs=500, converged=0.
REQ-034 Ties: a[2][5]=a[7][9]=a[2][30]=40, all other off-diagonal elements less than 40: expect p=2, q=5.
REQ-035 Saturation: a[0][31]=0x80000000 and a[1][2]=0x7FFFFFFF: expect p=0, q=31, max_abs=0x7FFFFFFF.
REQ-036 Reset at cycle 10 of a scan: expect no done pulse, ram_ena=0 from the next cycle, then a new start completes normally 34 cycles later.
REQ-037 start re-pulsed at cycles 5 and 34: both ignored, exactly one done, and the address sequence is 0..31 with no gaps.
